// File: rtl/moxie_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port, one transaction in flight.
// Define MOXIE_ARB_RR_EN for round-robin arbitration; otherwise ls has fixed priority.
module moxie_mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_be,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t state_reg, state_next;
  logic   pick_ls;
  logic   grant_if, grant_ls;

`ifdef MOXIE_ARB_RR_EN
  // Cleared value lets ls take the first contention after reset.
  logic last_ls_reg;

  assign pick_ls = ls_req & (~if_req | ~last_ls_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ls_reg <= 1'b0;
    end else if (grant_ls || grant_if) begin
      last_ls_reg <= grant_ls;
    end
  end
`else
  assign pick_ls = ls_req;
`endif

  assign grant_ls = (state_reg == IDLE) & pick_ls;
  assign grant_if = (state_reg == IDLE) & if_req & ~pick_ls;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_ls)      state_next = BUSY_LS;
        else if (grant_if) state_next = BUSY_IF;
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    if (state_reg != IDLE) mem_req = 1'b1;
  end

  // Command, grant and completion registers; command is only loaded at grant time.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if_gnt    <= grant_if;
      ls_gnt    <= grant_ls;
      if_rvalid <= (state_reg == BUSY_IF) && mem_ack;
      ls_rvalid <= (state_reg == BUSY_LS) && mem_ack;
      if (grant_ls) begin
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_be    <= ls_be;
      end else if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= 4'b1111;
      end
      if ((state_reg == BUSY_IF) && mem_ack) if_rdata <= mem_rdata;
      if ((state_reg == BUSY_LS) && mem_ack) ls_rdata <= mem_rdata;
    end
  end

endmodule
